sccb_rom_loader: RTL and testbench

Camera register-table sequencer that sits directly downstream of the Gowin_pROM register table. After power-up it walks the ROM two 16-bit words per entry (register address, then register data) and issues one 3-phase SCCB write (ID, addr-hi, addr-lo, data) per entry to the OV5640. It stops at the 0xFFFF address terminator and then asserts `done`.

---
 rtl/sccb_rom_loader_if.sv | 26 ++
 rtl/sccb_rom_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_sccb_rom_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sccb_rom_loader_if.sv
// Loader bus bundle: ROM fetch port, SCCB pads and control/status.
// The master side is the loader; the slave side is the ROM/pad/system environment.
interface sccb_rom_loader_if;
  logic        start;
  logic [8:0]  rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [15:0] rom_dout;
  logic        sccb_scl;
  logic        sio_d_oe;
  logic        sio_d_i;
  logic        busy;
  logic        done;
  logic        nack;
  logic [7:0]  wr_count;

  modport master (
    input  start, rom_dout, sio_d_i,
    output rom_ad, rom_ce, rom_oce, sccb_scl, sio_d_oe, busy, done, nack, wr_count
  );

  modport slave (
    output start, rom_dout, sio_d_i,
    input  rom_ad, rom_ce, rom_oce, sccb_scl, sio_d_oe, busy, done, nack, wr_count
  );
endinterface

// File: rtl/sccb_rom_loader.sv
// Walks the register ROM (addr word, data word) and issues one SCCB 3-phase write per entry until 0xFFFF.
// Latency: 152*QDIV clk per write plus GAP_Q*QDIV gap and 5 clk fetch/check; no backpressure, start ignored while busy.
module sccb_rom_loader #(
  parameter int          QDIV      = 67,
  parameter int          PWRUP_CYC = 540000,
  parameter int          GAP_Q     = 8,
  parameter logic [7:0]  SLAVE_ID  = 8'h78
) (
  input  logic clk,
  input  logic rst_n,
  sccb_rom_loader_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH_A, S_FETCH_D, S_CHECK,
    S_START, S_BYTE, S_STOP, S_GAP, S_DONE
  } state_t;

  localparam int QW = $clog2(QDIV + 1);
  localparam int CW = $clog2(PWRUP_CYC + GAP_Q + 2);

  state_t         state;
  logic [QW-1:0]  qcnt;
  logic [CW-1:0]  cnt;
  logic [1:0]     qtr;
  logic [3:0]     bit_cnt;
  logic [1:0]     byte_cnt;
  logic [7:0]     sh;
  logic [7:0]     n;
  logic           tbl_end;
  logic           phase;
  logic [15:0]    reg_addr;
  logic [7:0]     reg_data;
  logic [7:0]     next_byte;
  logic           tick;
  logic           bus_phase;

  assign bus.rom_oce = 1'b1;
  assign tick        = (qcnt == QW'(QDIV - 1));
  assign bus_phase   = (state == S_START) || (state == S_BYTE) ||
                       (state == S_STOP)  || (state == S_GAP);

  always_comb begin
    next_byte = reg_data;
    case (byte_cnt)
      2'd0:    next_byte = reg_addr[15:8];
      2'd1:    next_byte = reg_addr[7:0];
      default: next_byte = reg_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      qcnt         <= '0;
      cnt          <= '0;
      qtr          <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      sh           <= '0;
      n            <= '0;
      tbl_end      <= 1'b0;
      phase        <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
      bus.rom_ad   <= '0;
      bus.rom_ce   <= 1'b0;
      bus.sccb_scl <= 1'b1;
      bus.sio_d_oe <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.nack     <= 1'b0;
      bus.wr_count <= '0;
    end else begin
      // Quarter divider only runs on the bus; it sits at 0 in CHECK so START gets a full first quarter.
      if (bus_phase && !tick) qcnt <= qcnt + 1'b1;
      else                    qcnt <= '0;

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state        <= S_PWRUP;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
            bus.nack     <= 1'b0;
            bus.wr_count <= '0;
            bus.rom_ad   <= '0;
            n            <= '0;
            tbl_end      <= 1'b0;
            cnt          <= '0;
          end
        end
        S_PWRUP: begin
          if (cnt == CW'(PWRUP_CYC - 1)) begin
            state      <= S_FETCH_A;
            bus.rom_ce <= 1'b1;
            bus.rom_ad <= {n, 1'b0};
            phase      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH_A: begin
          if (!phase) begin
            bus.rom_ce <= 1'b0;
            phase      <= 1'b1;
          end else begin
            reg_addr   <= bus.rom_dout;
            state      <= S_FETCH_D;
            bus.rom_ce <= 1'b1;
            bus.rom_ad <= {n, 1'b1};
            phase      <= 1'b0;
          end
        end
        S_FETCH_D: begin
          if (!phase) begin
            bus.rom_ce <= 1'b0;
            phase      <= 1'b1;
          end else begin
            reg_data <= bus.rom_dout[7:0];
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (reg_addr == 16'hFFFF || tbl_end) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state <= S_START;
            qtr   <= '0;
            sh    <= SLAVE_ID;
          end
        end
        S_START: begin
          if (tick) begin
            if (qtr == 2'd3) begin
              state        <= S_BYTE;
              qtr          <= '0;
              bit_cnt      <= '0;
              byte_cnt     <= '0;
              bus.sio_d_oe <= ~sh[7];
            end else begin
              qtr          <= qtr + 2'd1;
              bus.sccb_scl <= (qtr != 2'd2);
              bus.sio_d_oe <= 1'b1;
            end
          end
        end
        S_BYTE: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: bus.sccb_scl <= 1'b1;
              2'd1: ;
              2'd2: begin
                bus.sccb_scl <= 1'b0;
                if (bit_cnt == 4'd8 && bus.sio_d_i) bus.nack <= 1'b1;
              end
              default: begin
                if (bit_cnt == 4'd8) begin
                  bit_cnt <= '0;
                  if (byte_cnt == 2'd3) begin
                    state        <= S_STOP;
                    bus.sio_d_oe <= 1'b1;
                  end else begin
                    byte_cnt     <= byte_cnt + 2'd1;
                    sh           <= next_byte;
                    bus.sio_d_oe <= ~next_byte[7];
                  end
                end else if (bit_cnt == 4'd7) begin
                  bit_cnt      <= 4'd8;
                  bus.sio_d_oe <= 1'b0;
                end else begin
                  bit_cnt      <= bit_cnt + 4'd1;
                  sh           <= {sh[6:0], 1'b0};
                  bus.sio_d_oe <= ~sh[6];
                end
              end
            endcase
          end
        end
        S_STOP: begin
          if (tick) begin
            qtr <= qtr + 2'd1;
            case (qtr)
              2'd0: bus.sccb_scl <= 1'b1;
              2'd1: bus.sio_d_oe <= 1'b0;
              2'd2: ;
              default: begin
                state <= S_GAP;
                cnt   <= '0;
                if (bus.wr_count != 8'hFF) bus.wr_count <= bus.wr_count + 8'd1;
                // Entry 255 was the last one: flag it instead of wrapping n back to 0.
                if (n == 8'hFF) tbl_end <= 1'b1;
                else            n       <= n + 8'd1;
              end
            endcase
          end
        end
        S_GAP: begin
          if (tick) begin
            if (cnt == CW'(GAP_Q - 1)) begin
              if (tbl_end) begin
                state <= S_CHECK;
              end else begin
                state      <= S_FETCH_A;
                bus.rom_ce <= 1'b1;
                bus.rom_ad <= {n, 1'b0};
                phase      <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_rom_loader.sv
// Bench for sccb_rom_loader: ROM and SCCB slave models, bus decoder/monitor, table-driven and random runs.
module tb_sccb_rom_loader;
  localparam int         QDIV   = 2;
  localparam int         PWRUP  = 10;
  localparam int         GAP_Q  = 2;
  localparam logic [7:0] SID    = 8'h78;
  localparam int         PERIOD = (152 + GAP_Q) * QDIV + 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sccb_rom_loader_if bus_if();

  sccb_rom_loader #(.QDIV(QDIV), .PWRUP_CYC(PWRUP), .GAP_Q(GAP_Q), .SLAVE_ID(SID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [15:0] mem [0:511];
  always @(posedge clk) if (bus_if.rom_ce) bus_if.rom_dout <= mem[bus_if.rom_ad];

  logic ack_drive = 1'b0;
  assign bus_if.sio_d_i = ~(bus_if.sio_d_oe | ack_drive);

  int checks = 0;
  int errors = 0;
  int run_id = 0;
  int nack_w = -1;
  int nack_b = 0;

  // Monitor state, owned by the always block below.
  int seen_id = 0, cyc = 0, bitn = 0;
  int proto_err = 0, tim_err = 0, fetch_err = 0, last_ad = -1;
  int last_start = 0, last_stop = 0;
  bit in_write = 0, have_start = 0, have_stop = 0;
  logic prev_scl = 1'b1, prev_oe = 1'b0;
  logic [31:0] wd = '0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    cyc++;
    if (run_id != seen_id) begin
      seen_id = run_id; got_q.delete(); in_write = 0; bitn = 0;
      proto_err = 0; tim_err = 0; fetch_err = 0; last_ad = -1;
      have_start = 0; have_stop = 0; ack_drive = 1'b0;
    end else begin
      if (bus_if.rom_ce) begin
        if (int'(bus_if.rom_ad) != last_ad + 1) fetch_err++;
        last_ad = int'(bus_if.rom_ad);
      end
      if (prev_scl != bus_if.sccb_scl && prev_oe != bus_if.sio_d_oe) proto_err++;
      if (prev_scl && bus_if.sccb_scl && !prev_oe && bus_if.sio_d_oe) begin
        if (in_write) proto_err++;
        if (have_start && cyc - last_start != PERIOD) tim_err++;
        if (have_stop && cyc - last_stop < GAP_Q * QDIV) tim_err++;
        in_write = 1; bitn = 0; wd = '0; have_start = 1; last_start = cyc;
      end else if (prev_scl && bus_if.sccb_scl && prev_oe && !bus_if.sio_d_oe) begin
        // 36 bit clocks plus the STOP clock
        if (!in_write || bitn != 37) proto_err++;
        if (cyc - last_start != 149 * QDIV) tim_err++;
        got_q.push_back(wd); in_write = 0; have_stop = 1; last_stop = cyc;
      end
      if (!prev_scl && bus_if.sccb_scl && in_write) begin
        if (bitn < 36 && bitn % 9 != 8) wd = {wd[30:0], ~bus_if.sio_d_oe};
        bitn++;
      end
      if (prev_scl && !bus_if.sccb_scl && in_write)
        ack_drive = (bitn % 9 == 8) && !(nack_w == got_q.size() && nack_b == bitn / 9);
    end
    prev_scl = bus_if.sccb_scl;
    prev_oe  = bus_if.sio_d_oe;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: every entry before the first 0xFFFF address (at most 256) becomes one write.
  task automatic build_model();
    exp_q.delete();
    for (int e = 0; e < 256; e++) begin
      if (mem[2*e] == 16'hFFFF) break;
      exp_q.push_back({SID, mem[2*e], mem[2*e+1][7:0]});
    end
  endtask

  task automatic fill_rom(input bit spec_tbl, input int n_ent);
    for (int a = 0; a < 512; a++) mem[a] = 16'($urandom);
    if (spec_tbl) begin
      mem[0] = 16'h3103; mem[1] = 16'h0011; mem[2] = 16'h3008;
      mem[3] = 16'h0082; mem[4] = 16'hFFFF; mem[5] = 16'hFFFF;
    end else begin
      for (int e = 0; e < 256; e++)
        if (e < n_ent || n_ent < 0) mem[2*e] = 16'($urandom_range(0, 16'hFFFE));
        else if (e == n_ent)        mem[2*e] = 16'hFFFF;
    end
  endtask

  task automatic launch();
    run_id++;
    @(negedge clk); bus_if.start = 1'b1;
    @(negedge clk); bus_if.start = 1'b0;
  endtask

  task automatic check_run(input string nm, input int exp_wc, input bit exp_nack);
    int k;
    k = 0;
    while (!bus_if.done && k < (exp_q.size() + 1) * PERIOD + 100) begin
      @(negedge clk); k++;
    end
    chk({nm, " done"}, 32'(bus_if.done), 32'd1);
    chk({nm, " busy"}, 32'(bus_if.busy), 32'd0);
    chk({nm, " wr_count"}, 32'(bus_if.wr_count), 32'(exp_wc));
    chk({nm, " nack"}, 32'(bus_if.nack), 32'(exp_nack));
    chk({nm, " n_writes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s write%0d", nm, i), got_q[i], exp_q[i]);
    chk({nm, " protocol"}, 32'(proto_err), 32'd0);
    chk({nm, " timing"}, 32'(tim_err), 32'd0);
    chk({nm, " fetch_order"}, 32'(fetch_err), 32'd0);
  endtask

  typedef struct {
    bit spec_tbl;
    int n_ent;
    int nack_w;
    int nack_b;
    int exp_writes;
    bit exp_nack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    bus_if.start = 1'b0;
    vecs[0] = '{1'b1, 2, -1, 0, 2, 1'b0};
    vecs[1] = '{1'b1, 2,  0, 2, 2, 1'b1};
    vecs[2] = '{1'b0, 3, -1, 0, 3, 1'b0};
    vecs[3] = '{1'b0, 1,  0, 0, 1, 1'b1};
    vecs[4] = '{1'b0, 0,  0, 1, 0, 1'b0};
    vecs[5] = '{1'b0, 2,  1, 3, 2, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst rom_ad", 32'(bus_if.rom_ad), 32'd0);
    chk("rst rom_ce", 32'(bus_if.rom_ce), 32'd0);
    chk("rst rom_oce", 32'(bus_if.rom_oce), 32'd1);
    chk("rst scl", 32'(bus_if.sccb_scl), 32'd1);
    chk("rst sio_d_oe", 32'(bus_if.sio_d_oe), 32'd0);
    chk("rst busy", 32'(bus_if.busy), 32'd0);
    chk("rst done", 32'(bus_if.done), 32'd0);
    chk("rst nack", 32'(bus_if.nack), 32'd0);
    chk("rst wr_count", 32'(bus_if.wr_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      fill_rom(vecs[i].spec_tbl, vecs[i].n_ent);
      nack_w = vecs[i].nack_w; nack_b = vecs[i].nack_b;
      build_model();
      launch();
      check_run($sformatf("vec%0d", i), vecs[i].exp_writes, vecs[i].exp_nack);
    end

    // Restart from DONE with nack set: status clears at once and the table replays.
    nack_w = -1;
    launch();
    chk("restart done", 32'(bus_if.done), 32'd0);
    chk("restart busy", 32'(bus_if.busy), 32'd1);
    chk("restart nack", 32'(bus_if.nack), 32'd0);
    chk("restart wr_count", 32'(bus_if.wr_count), 32'd0);
    check_run("replay", 2, 1'b0);

    fill_rom(1'b1, 2); build_model();
    launch();
    repeat (400) @(negedge clk);
    bus_if.start = 1'b1; @(negedge clk); bus_if.start = 1'b0;
    check_run("start_busy", 2, 1'b0);

    // Reset while byte 2 of write 1 is driving SIO_D low with SCL low.
    launch();
    k = 0;
    while (!(in_write && got_q.size() == 0 && bitn >= 9 && bitn < 18 &&
             !bus_if.sccb_scl && bus_if.sio_d_oe) && k < 1000) begin
      @(negedge clk); k++;
    end
    chk("midrst reached", 32'(k < 1000), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst scl", 32'(bus_if.sccb_scl), 32'd1);
    chk("midrst sio_d_oe", 32'(bus_if.sio_d_oe), 32'd0);
    chk("midrst busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    launch();
    check_run("after_rst", 2, 1'b0);

    fill_rom(1'b0, -1); build_model();
    launch();
    check_run("full_tbl", 255, 1'b0);
    chk("full_tbl last_ad", 32'(last_ad), 32'd511);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
